// File: rtl/can_sched_pkg.sv
// Shared types for the CAN transmit scheduler: field widths, FSM encoding and
// the order in which simultaneous WAIT-state events are honoured.
package can_sched_pkg;

  localparam int ID_W   = 11;
  localparam int DLC_W  = 4;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 3;
  localparam int RCNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_ABORT   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    EV_SUCCESS = 3'd1,
    EV_BUSOFF  = 3'd2,
    EV_ABORT   = 3'd3,
    EV_ERROR   = 3'd4,
    EV_TIMEOUT = 3'd5
  } wait_evt_e;

  // Highest-priority event first: an acknowledged frame always counts as sent.
  function automatic wait_evt_e wait_event(input logic success, input logic busoff,
                                           input logic abort_act, input logic error,
                                           input logic timeout);
    if (success)        return EV_SUCCESS;
    else if (busoff)    return EV_BUSOFF;
    else if (abort_act) return EV_ABORT;
    else if (error)     return EV_ERROR;
    else if (timeout)   return EV_TIMEOUT;
    else                return EV_NONE;
  endfunction

endpackage

// File: rtl/can_tx_scheduler_if.sv
// Mailbox/register-file and CAN core signals seen by the transmit scheduler.
interface can_tx_scheduler_if
  import can_sched_pkg::*;
#(
  parameter int NUM_MB = 4
);
  logic [NUM_MB-1:0]        mb_req;
  logic [NUM_MB-1:0]        mb_abort;
  logic [NUM_MB*ID_W-1:0]   mb_id;
  logic [NUM_MB*DLC_W-1:0]  mb_dlc;
  logic [NUM_MB*DATA_W-1:0] mb_data;
  logic [NUM_MB-1:0]        mb_pending;
  logic [NUM_MB-1:0]        mb_done;
  logic [NUM_MB-1:0]        mb_fail;
  logic                     busy;
  logic [IDX_W-1:0]         active_idx;
  logic                     can_tx_request;
  logic [ID_W-1:0]          can_tx_id;
  logic [DLC_W-1:0]         can_tx_dlc;
  logic [DATA_W-1:0]        can_tx_data;
  logic                     can_abort_tx;
  logic                     can_tx_success;
  logic                     can_error_irq;
  logic                     can_error_status;

  modport slave (
    input  mb_req, mb_abort, mb_id, mb_dlc, mb_data,
    input  can_tx_success, can_error_irq, can_error_status,
    output mb_pending, mb_done, mb_fail, busy, active_idx,
    output can_tx_request, can_tx_id, can_tx_dlc, can_tx_data, can_abort_tx
  );

  modport master (
    output mb_req, mb_abort, mb_id, mb_dlc, mb_data,
    output can_tx_success, can_error_irq, can_error_status,
    input  mb_pending, mb_done, mb_fail, busy, active_idx,
    input  can_tx_request, can_tx_id, can_tx_dlc, can_tx_data, can_abort_tx
  );
endinterface

// File: rtl/can_prio_select.sv
// Combinational minimum-identifier search; strict compare keeps the lowest
// index on equal identifiers.
module can_prio_select
  import can_sched_pkg::*;
#(
  parameter int NUM_MB = 4
) (
  input  logic [NUM_MB-1:0]      cand_i,
  input  logic [NUM_MB*ID_W-1:0] id_i,
  output logic [IDX_W-1:0]       win_idx_o,
  output logic                   win_valid_o
);

  logic [ID_W-1:0]  best_id_s;
  logic [IDX_W-1:0] best_idx_s;
  logic             best_vld_s;
  logic             take_s;

  always_comb begin
    best_id_s  = '0;
    best_idx_s = '0;
    best_vld_s = 1'b0;
    take_s     = 1'b0;
    for (int i = 0; i < NUM_MB; i++) begin
      take_s     = cand_i[i] && (!best_vld_s || (id_i[i*ID_W +: ID_W] < best_id_s));
      best_id_s  = take_s ? id_i[i*ID_W +: ID_W] : best_id_s;
      best_idx_s = take_s ? IDX_W'(i) : best_idx_s;
      best_vld_s = best_vld_s | take_s;
    end
  end

  assign win_idx_o   = best_idx_s;
  assign win_valid_o = best_vld_s;

endmodule

// File: rtl/can_tx_scheduler.sv
// Arbitrates mailbox transmit requests onto the single CAN core transmit path,
// handling retries, timeouts, aborts and bus-off.
module can_tx_scheduler
  import can_sched_pkg::*;
#(
  parameter int NUM_MB    = 4,
  parameter int RETRY_MAX = 8,
  parameter int TIMEOUT   = 200000
) (
  input logic             clk_sys,
  input logic             rst,
  can_tx_scheduler_if.slave bus
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [RCNT_W-1:0] RETRY_LAST = RCNT_W'(RETRY_MAX - 1);

  state_e              state_q, state_d;
  logic [NUM_MB-1:0]   pending_q, pending_d, keep_s, new_s, cand_s;
  logic [NUM_MB-1:0]   fsm_clr_s, act_oh_s;
  logic [NUM_MB-1:0]   done_q, done_d, fail_q, fail_d;
  logic [RCNT_W-1:0]   retry_q [NUM_MB];
  logic [RCNT_W-1:0]   retry_act_s;
  logic                retry_inc_s;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [IDX_W-1:0]    act_q, act_d, win_idx_s;
  logic                win_valid_s, act_abort_s;
  logic [ID_W-1:0]     id_q, id_d, sel_id_s;
  logic [DLC_W-1:0]    dlc_q, dlc_d, sel_dlc_s;
  logic [DATA_W-1:0]   data_q, data_d, sel_data_s;
  logic                req_q, abort_q, busy_q;
  wait_evt_e           evt_s;

  // A mailbox aborted in the same cycle must not win arbitration.
  assign cand_s = pending_q & ~bus.mb_abort;

  can_prio_select #(.NUM_MB(NUM_MB)) u_prio (
    .cand_i      (cand_s),
    .id_i        (bus.mb_id),
    .win_idx_o   (win_idx_s),
    .win_valid_o (win_valid_s)
  );

  always_comb begin
    sel_id_s    = '0;
    sel_dlc_s   = '0;
    sel_data_s  = '0;
    act_oh_s    = '0;
    retry_act_s = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      sel_id_s    = (win_idx_s == IDX_W'(i)) ? bus.mb_id[i*ID_W +: ID_W] : sel_id_s;
      sel_dlc_s   = (win_idx_s == IDX_W'(i)) ? bus.mb_dlc[i*DLC_W +: DLC_W] : sel_dlc_s;
      sel_data_s  = (win_idx_s == IDX_W'(i)) ? bus.mb_data[i*DATA_W +: DATA_W] : sel_data_s;
      act_oh_s[i] = (act_q == IDX_W'(i));
      retry_act_s = act_oh_s[i] ? retry_q[i] : retry_act_s;
    end
  end

  assign act_abort_s = |(bus.mb_abort & act_oh_s);
  assign evt_s = wait_event(bus.can_tx_success, bus.can_error_status, act_abort_s,
                            bus.can_error_irq, (tmo_q == TMO_LAST));

  // A request on a mailbox whose pending bit is being cleared starts a fresh frame.
  assign keep_s    = pending_q & ~(bus.mb_abort | fsm_clr_s);
  assign pending_d = bus.mb_req | keep_s;
  assign new_s     = bus.mb_req & ~keep_s;

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    id_d        = id_q;
    dlc_d       = dlc_q;
    data_d      = data_q;
    tmo_d       = tmo_q;
    fsm_clr_s   = '0;
    done_d      = '0;
    fail_d      = '0;
    retry_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|pending_q) && !bus.can_error_status) state_d = ST_SELECT;
        else                                       state_d = ST_IDLE;
      end
      ST_SELECT: begin
        if (win_valid_s) begin
          state_d = ST_WAIT;
          act_d   = win_idx_s;
          id_d    = sel_id_s;
          dlc_d   = sel_dlc_s;
          data_d  = sel_data_s;
          tmo_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        case (evt_s)
          EV_SUCCESS: begin
            done_d    = act_oh_s;
            fsm_clr_s = act_oh_s;
            state_d   = ST_IDLE;
          end
          EV_BUSOFF: state_d = ST_ABORT;
          EV_ABORT: begin
            fsm_clr_s = act_oh_s;
            state_d   = ST_ABORT;
          end
          EV_ERROR: begin
            if (retry_act_s == RETRY_LAST) begin
              fail_d    = act_oh_s;
              fsm_clr_s = act_oh_s;
              state_d   = ST_ABORT;
            end else begin
              retry_inc_s = 1'b1;
              state_d     = ST_BACKOFF;
            end
          end
          EV_TIMEOUT: begin
            fail_d    = act_oh_s;
            fsm_clr_s = act_oh_s;
            state_d   = ST_ABORT;
          end
          default: state_d = ST_WAIT;
        endcase
      end
      ST_BACKOFF: state_d = ST_SELECT;
      ST_ABORT:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      done_q    <= '0;
      fail_q    <= '0;
      tmo_q     <= '0;
      act_q     <= '0;
      id_q      <= '0;
      dlc_q     <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      act_q     <= act_d;
      id_q      <= id_d;
      dlc_q     <= dlc_d;
      data_q    <= data_d;
      req_q     <= (state_d == ST_WAIT);
      abort_q   <= (state_d == ST_ABORT);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  // Retry counts live per mailbox so a preempted frame resumes its count.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MB; i++) begin
        if (new_s[i])                         retry_q[i] <= '0;
        else if (retry_inc_s && act_oh_s[i])  retry_q[i] <= retry_q[i] + RCNT_W'(1);
        else                                  retry_q[i] <= retry_q[i];
      end
    end
  end

  assign bus.mb_pending     = pending_q;
  assign bus.mb_done        = done_q;
  assign bus.mb_fail        = fail_q;
  assign bus.busy           = busy_q;
  assign bus.active_idx     = act_q;
  assign bus.can_tx_request = req_q;
  assign bus.can_tx_id      = id_q;
  assign bus.can_tx_dlc     = dlc_q;
  assign bus.can_tx_data    = data_q;
  assign bus.can_abort_tx   = abort_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler (NUM_MB=4, RETRY_MAX=3, TIMEOUT=40).
module tb_can_tx_scheduler;
  import can_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  can_tx_scheduler_if #(.NUM_MB(4)) bus ();

  can_tx_scheduler #(.NUM_MB(4), .RETRY_MAX(3), .TIMEOUT(40)) dut (
    .clk_sys (clk),
    .rst     (rst),
    .bus     (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mb(input int idx, input logic [10:0] id, input logic [3:0] dlc,
                        input logic [63:0] data);
    bus.mb_id[idx*11 +: 11]   = id;
    bus.mb_dlc[idx*4 +: 4]    = dlc;
    bus.mb_data[idx*64 +: 64] = data;
  endtask

  task automatic pulse_req(input logic [3:0] m);
    bus.mb_req = m; step(); bus.mb_req = 4'b0000;
  endtask

  task automatic pulse_success();
    bus.can_tx_success = 1'b1; step(); bus.can_tx_success = 1'b0;
  endtask

  task automatic pulse_irq();
    bus.can_error_irq = 1'b1; step(); bus.can_error_irq = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (bus.can_tx_request !== 1'b1 && n < 100) begin
      step(); n++;
    end
  endtask

  task automatic test_reset();
    bus.mb_req = 4'b0; bus.mb_abort = 4'b0; bus.mb_id = '0; bus.mb_dlc = '0; bus.mb_data = '0;
    bus.can_tx_success = 1'b0; bus.can_error_irq = 1'b0; bus.can_error_status = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    vec_cnt++; if ({bus.mb_pending, bus.mb_done, bus.mb_fail} !== 12'h000) begin err_cnt++;
      $display("FAIL reset_mb: got %h want 000", {bus.mb_pending, bus.mb_done, bus.mb_fail}); end
    vec_cnt++; if ({bus.busy, bus.can_tx_request, bus.can_abort_tx, bus.active_idx} !== 6'b0) begin err_cnt++;
      $display("FAIL reset_ctl: got %b want 000000", {bus.busy, bus.can_tx_request, bus.can_abort_tx, bus.active_idx}); end
    vec_cnt++; if ({bus.can_tx_id, bus.can_tx_dlc, bus.can_tx_data} !== 79'h0) begin err_cnt++;
      $display("FAIL reset_frame: got %h want 0", {bus.can_tx_id, bus.can_tx_dlc, bus.can_tx_data}); end
  endtask

  task automatic test_single();
    int n;
    set_mb(1, 11'h123, 4'd8, 64'hDEAD_BEEF_0123_4567);
    pulse_req(4'b0010);
    vec_cnt++; if (bus.mb_pending !== 4'b0010) begin err_cnt++;
      $display("FAIL single_pending: got %b want 0010", bus.mb_pending); end
    wait_req(n);
    vec_cnt++; if (n !== 2) begin err_cnt++; $display("FAIL single_latency: got %0d want 2", n); end
    vec_cnt++; if ({bus.can_tx_id, bus.can_tx_dlc, bus.active_idx} !== {11'h123, 4'd8, 3'd1}) begin err_cnt++;
      $display("FAIL single_fields: got %h/%h/%h want 123/8/1", bus.can_tx_id, bus.can_tx_dlc, bus.active_idx); end
    vec_cnt++; if (bus.can_tx_data !== 64'hDEAD_BEEF_0123_4567) begin err_cnt++;
      $display("FAIL single_data: got %h want deadbeef01234567", bus.can_tx_data); end
    repeat (7) step();
    vec_cnt++; if ({bus.can_tx_request, bus.can_tx_id} !== {1'b1, 11'h123}) begin err_cnt++;
      $display("FAIL single_stable: got %b/%h want 1/123", bus.can_tx_request, bus.can_tx_id); end
    pulse_success();
    vec_cnt++; if ({bus.mb_done, bus.mb_pending, bus.can_tx_request, bus.busy} !== {4'b0010, 4'b0000, 2'b00}) begin err_cnt++;
      $display("FAIL single_done: got %b want 0010000000", {bus.mb_done, bus.mb_pending, bus.can_tx_request, bus.busy}); end
    step();
    vec_cnt++; if (bus.mb_done !== 4'b0000) begin err_cnt++;
      $display("FAIL single_done_pulse: got %b want 0000", bus.mb_done); end
  endtask

  task automatic test_priority();
    int n;
    set_mb(0, 11'h400, 4'd1, 64'h1);
    set_mb(3, 11'h010, 4'd2, 64'h2);
    pulse_req(4'b1001);
    wait_req(n);
    vec_cnt++; if ({bus.active_idx, bus.can_tx_id} !== {3'd3, 11'h010}) begin err_cnt++;
      $display("FAIL prio_first: got %0d/%h want 3/010", bus.active_idx, bus.can_tx_id); end
    pulse_success();
    vec_cnt++; if ({bus.mb_done, bus.mb_pending} !== {4'b1000, 4'b0001}) begin err_cnt++;
      $display("FAIL prio_done3: got %b want 10000001", {bus.mb_done, bus.mb_pending}); end
    wait_req(n);
    vec_cnt++; if ({n[3:0], bus.active_idx, bus.can_tx_id} !== {4'd2, 3'd0, 11'h400}) begin err_cnt++;
      $display("FAIL prio_second: got %0d/%0d/%h want 2/0/400", n, bus.active_idx, bus.can_tx_id); end
    pulse_success();
    set_mb(2, 11'h055, 4'd3, 64'h3);
    set_mb(3, 11'h055, 4'd4, 64'h4);
    step();
    pulse_req(4'b1100);
    wait_req(n);
    vec_cnt++; if (bus.active_idx !== 3'd2) begin err_cnt++;
      $display("FAIL prio_tie_first: got %0d want 2", bus.active_idx); end
    pulse_success();
    wait_req(n);
    vec_cnt++; if ({bus.active_idx, bus.can_tx_dlc} !== {3'd3, 4'd4}) begin err_cnt++;
      $display("FAIL prio_tie_second: got %0d/%0d want 3/4", bus.active_idx, bus.can_tx_dlc); end
    pulse_success();
    step();
  endtask

  task automatic test_retry_exhaust();
    int n;
    set_mb(1, 11'h222, 4'd5, 64'h5);
    pulse_req(4'b0010);
    wait_req(n);
    for (int k = 0; k < 2; k++) begin
      pulse_irq();
      vec_cnt++; if ({bus.can_tx_request, bus.mb_fail} !== 5'b0) begin err_cnt++;
        $display("FAIL retry_backoff%0d: got %b want 00000", k, {bus.can_tx_request, bus.mb_fail}); end
      wait_req(n);
      vec_cnt++; if (n !== 2) begin err_cnt++; $display("FAIL retry_gap%0d: got %0d want 2", k, n); end
    end
    pulse_irq();
    vec_cnt++; if ({bus.mb_fail, bus.can_abort_tx, bus.can_tx_request, bus.mb_pending} !== {4'b0010, 2'b10, 4'b0000}) begin err_cnt++;
      $display("FAIL retry_fail: got %b want 0010100000", {bus.mb_fail, bus.can_abort_tx, bus.can_tx_request, bus.mb_pending}); end
    step();
    vec_cnt++; if ({bus.mb_fail, bus.can_abort_tx, bus.busy} !== 6'b0) begin err_cnt++;
      $display("FAIL retry_after: got %b want 000000", {bus.mb_fail, bus.can_abort_tx, bus.busy}); end
  endtask

  task automatic test_preempt();
    int n;
    set_mb(2, 11'h300, 4'd6, 64'h6);
    set_mb(1, 11'h100, 4'd7, 64'h7);
    pulse_req(4'b0100);
    wait_req(n);
    pulse_irq();
    pulse_req(4'b0010);
    wait_req(n);
    vec_cnt++; if ({n[3:0], bus.active_idx, bus.can_tx_id} !== {4'd1, 3'd1, 11'h100}) begin err_cnt++;
      $display("FAIL preempt_winner: got %0d/%0d/%h want 1/1/100", n, bus.active_idx, bus.can_tx_id); end
    pulse_success();
    vec_cnt++; if (bus.mb_done !== 4'b0010) begin err_cnt++;
      $display("FAIL preempt_done1: got %b want 0010", bus.mb_done); end
    wait_req(n);
    vec_cnt++; if ({n[3:0], bus.active_idx} !== {4'd2, 3'd2}) begin err_cnt++;
      $display("FAIL preempt_resume: got %0d/%0d want 2/2", n, bus.active_idx); end
    pulse_irq();
    vec_cnt++; if (bus.mb_fail !== 4'b0000) begin err_cnt++;
      $display("FAIL preempt_retry2: got %b want 0000", bus.mb_fail); end
    wait_req(n);
    pulse_irq();
    vec_cnt++; if (bus.mb_fail !== 4'b0100) begin err_cnt++;
      $display("FAIL preempt_retry3: got %b want 0100", bus.mb_fail); end
    step();
  endtask

  task automatic test_busoff();
    int n;
    set_mb(0, 11'h111, 4'd2, 64'h8);
    pulse_req(4'b0001);
    wait_req(n);
    bus.can_error_status = 1'b1;
    step();
    vec_cnt++; if ({bus.can_abort_tx, bus.can_tx_request, bus.mb_pending, bus.mb_fail} !== {2'b10, 4'b0001, 4'b0000}) begin err_cnt++;
      $display("FAIL busoff_abort: got %b want 1000010000", {bus.can_abort_tx, bus.can_tx_request, bus.mb_pending, bus.mb_fail}); end
    repeat (5) step();
    vec_cnt++; if ({bus.can_tx_request, bus.busy, bus.can_abort_tx} !== 3'b000) begin err_cnt++;
      $display("FAIL busoff_hold: got %b want 000", {bus.can_tx_request, bus.busy, bus.can_abort_tx}); end
    bus.can_error_status = 1'b0;
    wait_req(n);
    vec_cnt++; if ({n[3:0], bus.active_idx, bus.can_tx_id} !== {4'd2, 3'd0, 11'h111}) begin err_cnt++;
      $display("FAIL busoff_resend: got %0d/%0d/%h want 2/0/111", n, bus.active_idx, bus.can_tx_id); end
    pulse_success();
    vec_cnt++; if (bus.mb_done !== 4'b0001) begin err_cnt++;
      $display("FAIL busoff_done: got %b want 0001", bus.mb_done); end
  endtask

  task automatic test_timeout();
    int n;
    set_mb(1, 11'h0AA, 4'd1, 64'h9);
    pulse_req(4'b0010);
    wait_req(n);
    n = 0;
    while (bus.mb_fail === 4'b0000 && n < 100) begin
      step(); n++;
    end
    vec_cnt++; if ({n[7:0], bus.mb_fail, bus.can_abort_tx, bus.can_tx_request} !== {8'd40, 4'b0010, 2'b10}) begin err_cnt++;
      $display("FAIL timeout: got %0d/%b/%b want 40/0010/1", n, bus.mb_fail, bus.can_abort_tx); end
    step();
  endtask

  task automatic test_back_to_back_abort();
    int n;
    set_mb(3, 11'h033, 4'd3, 64'hA);
    pulse_req(4'b1000);
    wait_req(n);
    bus.mb_abort = 4'b1000; bus.can_tx_success = 1'b1;
    step();
    bus.mb_abort = 4'b0000; bus.can_tx_success = 1'b0;
    vec_cnt++; if ({bus.mb_done, bus.can_abort_tx, bus.mb_pending} !== {4'b1000, 1'b0, 4'b0000}) begin err_cnt++;
      $display("FAIL collide_done: got %b want 100000000", {bus.mb_done, bus.can_abort_tx, bus.mb_pending}); end
    step();
    pulse_req(4'b1000);
    wait_req(n);
    bus.mb_abort = 4'b1000;
    step();
    bus.mb_abort = 4'b0000;
    vec_cnt++; if ({bus.can_abort_tx, bus.mb_done, bus.mb_fail, bus.mb_pending} !== 13'b1_0000_0000_0000) begin err_cnt++;
      $display("FAIL abort_active: got %b want 1000000000000", {bus.can_abort_tx, bus.mb_done, bus.mb_fail, bus.mb_pending}); end
    step();
    set_mb(0, 11'h400, 4'd1, 64'h1);
    pulse_req(4'b1001);
    wait_req(n);
    bus.mb_abort = 4'b0001;
    step();
    bus.mb_abort = 4'b0000;
    vec_cnt++; if ({bus.mb_pending, bus.can_tx_request, bus.active_idx} !== {4'b1000, 1'b1, 3'd3}) begin err_cnt++;
      $display("FAIL abort_nonactive: got %b/%b/%0d want 1000/1/3", bus.mb_pending, bus.can_tx_request, bus.active_idx); end
    pulse_success();
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    pulse_req(4'b0001);
    wait_req(n);
    #3 rst = 1'b1;
    #1;
    vec_cnt++; if ({bus.can_tx_request, bus.busy, bus.can_abort_tx, bus.mb_pending, bus.can_tx_id} !== 18'b0) begin err_cnt++;
      $display("FAIL reset_mid: got %b/%b/%b/%b/%h want all 0", bus.can_tx_request, bus.busy, bus.can_abort_tx, bus.mb_pending, bus.can_tx_id); end
    step();
    rst = 1'b0;
    step();
    vec_cnt++; if ({bus.can_abort_tx, bus.can_tx_request, bus.busy} !== 3'b000) begin err_cnt++;
      $display("FAIL reset_mid_after: got %b want 000", {bus.can_abort_tx, bus.can_tx_request, bus.busy}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_retry_exhaust();
    test_preempt();
    test_busoff();
    test_timeout();
    test_back_to_back_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
